debounce_pulse: RTL and testbench



---
 rtl/debounce_pkg.sv | 19 +
 rtl/sync2.sv | 30 +++
 rtl/debounce_pulse.sv | 170 +++++++++++++++++
 tb/tb_debounce_pulse.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button conditioning path.
//
// Contents:
//   state_e                 - press/release FSM state (2-bit encoding)
//   DEFAULT_DEBOUNCE_CYCLES - stable cycles needed to accept a press/release
//   DEFAULT_REPEAT_CYCLES   - hold-to-repeat interval (AUTO_REPEAT_EN builds)
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_REPEAT_CYCLES   = 256;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous bit.
//
// Ports:
//   ck  - clock
//   rst - synchronous active-high reset, clears both flops to 0
//   d   - asynchronous input
//   q   - synchronised output, two ck cycles behind d
module sync2 (
  input  logic ck,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge ck) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/debounce_pulse.sv
// Push-button conditioner: synchronises a bouncy contact, debounces it with
// a press/release FSM, and produces a one-cycle count-enable pulse per
// accepted press plus a debounced level.
//
// Build option:
//   AUTO_REPEAT_EN - when defined, holding the button emits an extra pulse
//                    every REPEAT_CYCLES cycles while in PRESSED.
//
// Ports:
//   ck      - clock, all state updates on the rising edge
//   rst     - synchronous active-high reset
//   btn     - raw asynchronous contact input
//   pulse   - registered, high for one ck cycle per accepted press/repeat
//   level   - registered, debounced button state
//   state_o - current FSM state (debug observation)
//
// Handshake: none; pulse is a plain one-cycle strobe with no back-pressure.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic   ck,
  input  logic   rst,
  input  logic   btn,
  output logic   pulse,
  output logic   level,
  output state_e state_o
);

  // Elaboration-time guards on the legal parameter ranges.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 2..65535");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 2");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic s2;

  sync2 u_sync (
    .ck  (ck),
    .rst (rst),
    .d   (btn),
    .q   (s2)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          pulse_q, pulse_d;
  logic          level_q, level_d;

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_q, rep_d;
`endif

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge ck) begin
    if (rst) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`endif

  // The debounce counter is cleared on every state change; it only counts
  // while a WAIT state keeps seeing the candidate value, and the transition
  // at CNT_LAST means it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
`ifdef AUTO_REPEAT_EN
    rep_d   = rep_q;
`endif

    case (state_q)
      IDLE: begin
        if (s2) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!s2) begin
          // Bounce: drop back without touching the outputs.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
          level_d = 1'b1;
`ifdef AUTO_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      PRESSED: begin
        if (!s2) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef AUTO_REPEAT_EN
        else if (rep_q == REP_LAST) begin
          pulse_d = 1'b1;
          rep_d   = '0;
        end else begin
          rep_d = rep_q + RW'(1);
        end
`endif
      end

      RELEASE_WAIT: begin
        if (s2) begin
          // Bounce on release: return to PRESSED with no new pulse.
          state_d = PRESSED;
          cnt_d   = '0;
`ifdef AUTO_REPEAT_EN
          rep_d   = '0;
`endif
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign pulse   = pulse_q;
  assign level   = level_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Bench for debounce_pulse with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// The reference model tracks the synchroniser delay with a small queue and
// decides acceptance by counting how long the synchronised input has
// disagreed with the debounced level; repeats are counted as a hold time.
module tb_debounce_pulse;
  import debounce_pkg::*;

  localparam int N = 4;
  localparam int R = 8;

  logic   ck  = 1'b0;
  logic   rst = 1'b1;
  logic   btn = 1'b0;
  logic   pulse;
  logic   level;
  state_e state_o;

  debounce_pulse #(
    .DEBOUNCE_CYCLES (N),
    .REPEAT_CYCLES   (R)
  ) dut (
    .ck      (ck),
    .rst     (rst),
    .btn     (btn),
    .pulse   (pulse),
    .level   (level),
    .state_o (state_o)
  );

  // ---------------- clock ----------------
  always #5 ck = ~ck;

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // ---------------- reference model ----------------
  logic hist[$];
  logic m_level;
  logic m_pulse;
  logic m_prev;
  int   m_run;
  int   m_hold;

  function automatic void model_edge(input logic b, input logic r);
    logic s2;
    logic toggled;
    if (r) begin
      hist    = '{1'b0, 1'b0};
      m_level = 1'b0;
      m_pulse = 1'b0;
      m_prev  = 1'b0;
      m_run   = 0;
      m_hold  = 0;
      return;
    end
    s2 = hist.pop_front();
    hist.push_back(b);
    m_pulse = 1'b0;
    toggled = 1'b0;
    if (s2 != m_level) m_run++;
    else m_run = 0;
    if (m_run == N + 1) begin
      m_level = s2;
      m_run   = 0;
      toggled = 1'b1;
      if (s2) m_pulse = 1'b1;
    end
`ifdef AUTO_REPEAT_EN
    if (!toggled && m_level && s2 && m_prev) begin
      m_hold++;
      if (m_hold == R) begin
        m_pulse = 1'b1;
        m_hold  = 0;
      end
    end else begin
      m_hold = 0;
    end
`endif
    m_prev = s2;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic b, input logic r);
    btn = b;
    rst = r;
    @(posedge ck);
    model_edge(b, r);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      n_vec++;
      if (pulse !== 1'b0 || level !== 1'b0 || state_o !== IDLE) begin
        n_err++;
        $display("FAIL reset[%0d]: pulse=%b level=%b state=%0d, expected 0 0 0",
                 i, pulse, level, state_o);
      end
    end
  endtask

  task automatic test_clean_press();
    int first_edge;
    int n_pulse;
    int fall_edge;
    int exp_pulses;
    first_edge = -1;
    n_pulse    = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0);
      n_vec++;
      if (pulse !== m_pulse || level !== m_level) begin
        n_err++;
        $display("FAIL clean_press edge %0d: pulse=%b level=%b, expected %b %b",
                 i, pulse, level, m_pulse, m_level);
      end
      if (pulse === 1'b1) begin
        n_pulse++;
        if (first_edge < 0) first_edge = i;
      end
    end
`ifdef AUTO_REPEAT_EN
    exp_pulses = 2;
`else
    exp_pulses = 1;
`endif
    n_vec++;
    if (first_edge != N + 3) begin
      n_err++;
      $display("FAIL clean_press_latency: first pulse after edge %0d, expected %0d",
               first_edge, N + 3);
    end
    n_vec++;
    if (n_pulse != exp_pulses) begin
      n_err++;
      $display("FAIL clean_press_count: %0d pulses, expected %0d", n_pulse, exp_pulses);
    end
    fall_edge = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0);
      n_vec++;
      if (pulse !== m_pulse || level !== m_level) begin
        n_err++;
        $display("FAIL clean_release edge %0d: pulse=%b level=%b, expected %b %b",
                 i, pulse, level, m_pulse, m_level);
      end
      if (level === 1'b0 && fall_edge < 0) fall_edge = i;
    end
    n_vec++;
    if (fall_edge != N + 3) begin
      n_err++;
      $display("FAIL clean_release_latency: level fell after edge %0d, expected %0d",
               fall_edge, N + 3);
    end
  endtask

  task automatic test_press_bounce();
    logic [3:0] pat;
    int n_pulse;
    pat = 4'b0101;  // applied bit 0 first: 1,0,1,0
    n_pulse = 0;
    for (int i = 0; i < 14; i++) begin
      step((i < 4) ? pat[i] : 1'b0, 1'b0);
      n_vec++;
      if (pulse !== m_pulse || level !== m_level) begin
        n_err++;
        $display("FAIL press_bounce edge %0d: pulse=%b level=%b, expected %b %b",
                 i + 1, pulse, level, m_pulse, m_level);
      end
      if (pulse === 1'b1) n_pulse++;
    end
    n_vec++;
    if (n_pulse != 0 || level !== 1'b0 || state_o !== IDLE) begin
      n_err++;
      $display("FAIL press_bounce_end: pulses=%0d level=%b state=%0d, expected 0 0 0",
               n_pulse, level, state_o);
    end
  endtask

  task automatic test_release_bounce();
    logic [2:0] pat;
    int n_pulse;
    int fall_edge;
    pat = 3'b100;  // applied bit 0 first: 0,0,1
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    n_vec++;
    if (level !== 1'b1) begin
      n_err++;
      $display("FAIL release_bounce_setup: level=%b, expected 1", level);
    end
    n_pulse = 0;
    for (int i = 0; i < 3; i++) begin
      step(pat[i], 1'b0);
      if (pulse === 1'b1) n_pulse++;
    end
    fall_edge = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0);
      n_vec++;
      if (pulse !== m_pulse || level !== m_level) begin
        n_err++;
        $display("FAIL release_bounce edge %0d: pulse=%b level=%b, expected %b %b",
                 i, pulse, level, m_pulse, m_level);
      end
      if (pulse === 1'b1) n_pulse++;
      if (level === 1'b0 && fall_edge < 0) fall_edge = i;
    end
    n_vec++;
    if (n_pulse != 0 || fall_edge != N + 3) begin
      n_err++;
      $display("FAIL release_bounce_result: pulses=%0d fall_edge=%0d, expected 0 and %0d",
               n_pulse, fall_edge, N + 3);
    end
  endtask

  task automatic test_reset_mid();
    int first_edge;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    n_vec++;
    if (pulse !== 1'b0 || level !== 1'b0 || state_o !== IDLE) begin
      n_err++;
      $display("FAIL reset_mid: pulse=%b level=%b state=%0d, expected 0 0 0",
               pulse, level, state_o);
    end
    first_edge = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0);
      n_vec++;
      if (pulse !== m_pulse || level !== m_level) begin
        n_err++;
        $display("FAIL reset_mid_after edge %0d: pulse=%b level=%b, expected %b %b",
                 i, pulse, level, m_pulse, m_level);
      end
      if (pulse === 1'b1 && first_edge < 0) first_edge = i;
    end
    n_vec++;
    if (first_edge != N + 3) begin
      n_err++;
      $display("FAIL reset_mid_latency: first pulse after edge %0d, expected %0d",
               first_edge, N + 3);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_counter_integration();
    logic [3:0] count;
    count = 4'd0;
    for (int p = 1; p <= 16; p++) begin
      for (int i = 0; i < 10; i++) begin
        step(1'b1, 1'b0);
        if (pulse === 1'b1) count = count + 4'd1;
      end
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 1'b0);
        if (pulse === 1'b1) count = count + 4'd1;
      end
      if (p == 3) begin
        n_vec++;
        if (count !== 4'b0011) begin
          n_err++;
          $display("FAIL counter_3_presses: count=%b, expected 0011", count);
        end
      end
    end
    n_vec++;
    if (count !== 4'b0000) begin
      n_err++;
      $display("FAIL counter_16_presses: count=%b, expected 0000", count);
    end
  endtask

  task automatic test_auto_repeat();
    logic [15:0] got;
    logic [15:0] want;
    exp_q = {};
    exp_q.push_back(16'(N + 3));
`ifdef AUTO_REPEAT_EN
    for (int e = N + 3 + R; e <= 40; e += R) exp_q.push_back(16'(e));
`endif
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b0);
      if (pulse === 1'b1) begin
        got = 16'(i);
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL auto_repeat: unexpected pulse after edge %0d", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_err++;
            $display("FAIL auto_repeat: pulse after edge %0d, expected edge %0d", got, want);
          end
        end
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL auto_repeat_missing: %0d expected pulses never seen", exp_q.size());
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_random();
    int cyc;
    int len;
    logic b;
    logic r;
    cyc = 0;
    while (cyc < 1500) begin
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 2 * N + 4);
      for (int k = 0; k < len; k++) begin
        r = ($urandom_range(0, 99) == 0);
        step(b, r);
        cyc++;
        n_vec++;
        if (pulse !== m_pulse || level !== m_level) begin
          n_err++;
          $display("FAIL random cyc %0d: pulse=%b level=%b, expected %b %b",
                   cyc, pulse, level, m_pulse, m_level);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_reset_mid();
    test_counter_integration();
    test_auto_repeat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
